// File: rtl/rr_mux_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
// Imported by the picker and the arbiter top level.
package rr_mux_pkg;

    localparam int NREQ = 8;
    localparam int SELW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Binary requester index to its one-hot grant vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = {NREQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating priority search: first requester at or after ptr, wrapping modulo NREQ.
// Purely combinational.
module rr_pick
    import rr_mux_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        logic [SELW-1:0] pos;
        found = 1'b0;
        idx   = {SELW{1'b0}};
        pos   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos   = ptr + SELW'(k);
            idx   = req[pos] ? pos : idx;
            found = found | req[pos];
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning an 8:1 single-bit channel: bounded tenures,
// back-to-back handover, registered grant/select/valid and a gated data output.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] i,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] s,
    output logic            valid,
    output logic            Y
);

    localparam int              CNTW     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);

    state_e          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [SELW-1:0] s_q, s_d;
    logic            valid_q, valid_d;

    logic [SELW-1:0] pick_ptr_s;
    logic            pick_found_s;
    logic [SELW-1:0] pick_idx_s;
    logic            tenure_end_s;

    // While granted, the search starts just past the owner so it is considered last.
    always_comb begin
        if (state_q == GRANT) begin
            pick_ptr_s = owner_q + 3'd1;
        end else begin
            pick_ptr_s = ptr_q;
        end
    end

    // A departed owner has req[owner]=0, so it is excluded without explicit masking.
    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Tenure ends on release by the owner or when the hold budget is spent.
    always_comb begin
        tenure_end_s = (req[owner_q] == 1'b0) || (cnt_q == CNT_LAST);
    end

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = GRANT;
                    owner_d = pick_idx_s;
                    gnt_d   = idx_to_onehot(pick_idx_s);
                    s_d     = pick_idx_s;
                    valid_d = 1'b1;
                    cnt_d   = {CNTW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!tenure_end_s) begin
                    cnt_d = cnt_q + CNTW'(1);
                end else if (pick_found_s) begin
                    ptr_d   = owner_q + 3'd1;
                    owner_d = pick_idx_s;
                    gnt_d   = idx_to_onehot(pick_idx_s);
                    s_d     = pick_idx_s;
                    valid_d = 1'b1;
                    cnt_d   = {CNTW{1'b0}};
                end else begin
                    // s deliberately keeps its last value when the channel goes idle.
                    ptr_d   = owner_q + 3'd1;
                    state_d = IDLE;
                    gnt_d   = {NREQ{1'b0}};
                    valid_d = 1'b0;
                    cnt_d   = {CNTW{1'b0}};
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = {NREQ{1'b0}};
                valid_d = 1'b0;
                cnt_d   = {CNTW{1'b0}};
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= {SELW{1'b0}};
            owner_q <= {SELW{1'b0}};
            cnt_q   <= {CNTW{1'b0}};
            gnt_q   <= {NREQ{1'b0}};
            s_q     <= {SELW{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign valid = valid_q;
    assign Y     = i[s_q] & valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: HOLD_MAX=4 and HOLD_MAX=2 instances on shared stimulus,
// checked against a behavioural scoreboard model plus directed expectations.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] i;

    logic [7:0] gnt4, gnt2;
    logic [2:0] s4, s2;
    logic       valid4, valid2, y4, y2;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] s;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];

    logic       m_busy [2];
    logic [2:0] m_ptr  [2];
    logic [2:0] m_owner[2];
    logic [2:0] m_s    [2];
    logic [7:0] m_gnt  [2];
    int         m_cnt  [2];
    int         hold_of[2] = '{4, 2};

    always #5 clk = ~clk;

    rr_mux_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .i(i),
        .gnt(gnt4), .s(s4), .valid(valid4), .Y(y4)
    );

    rr_mux_arbiter #(.HOLD_MAX(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .i(i),
        .gnt(gnt2), .s(s2), .valid(valid2), .Y(y2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 1'b0;
            m_ptr[d]   = 3'd0;
            m_owner[d] = 3'd0;
            m_s[d]     = 3'd0;
            m_gnt[d]   = 8'h00;
            m_cnt[d]   = 0;
        end
    endtask

    // One clock edge of the reference behaviour for instance d, then queue its outputs.
    task automatic model_step(input int d);
        logic search;
        logic hit;
        int   win;
        int   n;
        search = 1'b1;
        if (m_busy[d]) begin
            if (req[m_owner[d]] && (m_cnt[d] != hold_of[d] - 1)) begin
                m_cnt[d]++;
                search = 1'b0;
            end else begin
                m_ptr[d] = m_owner[d] + 3'd1;
            end
        end
        if (search) begin
            hit = 1'b0;
            win = 0;
            for (int off = 0; off < 8; off++) begin
                n = (int'(m_ptr[d]) + off) % 8;
                if (!hit && req[n]) begin
                    hit = 1'b1;
                    win = n;
                end
            end
            if (hit) begin
                m_busy[d]  = 1'b1;
                m_owner[d] = 3'(win);
                m_s[d]     = 3'(win);
                m_gnt[d]   = 8'h01 << win;
                m_cnt[d]   = 0;
            end else begin
                m_busy[d] = 1'b0;
                m_gnt[d]  = 8'h00;
            end
        end
        exp_q.push_back('{gnt: m_gnt[d], s: m_s[d], valid: m_busy[d]});
    endtask

    // Drive one cycle of inputs, advance the model, compare both instances after the edge.
    task automatic cycle(input logic [7:0] r, input logic [7:0] d);
        exp_t e;
        req = r;
        i   = d;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("gnt4",   32'(gnt4),   32'(e.gnt));
        check_val("s4",     32'(s4),     32'(e.s));
        check_val("valid4", 32'(valid4), 32'(e.valid));
        check_val("y4",     32'(y4),     32'(i[e.s] & e.valid));
        e = exp_q.pop_front();
        check_val("gnt2",   32'(gnt2),   32'(e.gnt));
        check_val("s2",     32'(s2),     32'(e.s));
        check_val("valid2", 32'(valid2), 32'(e.valid));
        check_val("y2",     32'(y2),     32'(i[e.s] & e.valid));
    endtask

    // Assert reset between edges, check the immediate clear, release on the next edge.
    task automatic do_reset(input logic [7:0] next_req);
        #2;
        rst = 1'b1;
        req = next_req;
        #1;
        check_val("rst_gnt4",   32'(gnt4),   32'h0);
        check_val("rst_s4",     32'(s4),     32'h0);
        check_val("rst_valid4", 32'(valid4), 32'h0);
        check_val("rst_y4",     32'(y4),     32'h0);
        check_val("rst_gnt2",   32'(gnt2),   32'h0);
        check_val("rst_valid2", 32'(valid2), 32'h0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        i   = 8'hFF;
        model_reset();
        #2;
        check_val("por_gnt4",   32'(gnt4),   32'h0);
        check_val("por_s4",     32'(s4),     32'h0);
        check_val("por_valid4", 32'(valid4), 32'h0);
        check_val("por_y4",     32'(y4),     32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester 2 with its data bit toggling: fresh tenure every 4 cycles.
        for (int k = 0; k < 12; k++) begin
            cycle(8'h04, {5'b0, k[0] ? 1'b1 : 1'b0, 2'b0});
            check_val("single_s4",   32'(s4),   32'd2);
            check_val("single_gnt4", 32'(gnt4), 32'h04);
            check_val("single_cnt4", 32'(u_dut4.cnt_q), 32'(k % 4));
        end

        // Only requester leaves: channel goes idle, s holds, Y stays low.
        cycle(8'h00, 8'hFF);
        check_val("idle_valid4", 32'(valid4), 32'h0);
        check_val("idle_gnt4",   32'(gnt4),   32'h0);
        check_val("idle_s4",     32'(s4),     32'd2);
        check_val("idle_y4",     32'(y4),     32'h0);

        // Full rotation on the HOLD_MAX=2 instance.
        do_reset(8'h00);
        for (int k = 0; k < 18; k++) begin
            cycle(8'hFF, 8'($urandom));
            check_val("rot_s2",     32'(s2),     32'((k / 2) % 8));
            check_val("rot_valid2", 32'(valid2), 32'h1);
        end

        // Early release: owner 3 drops after one cycle while 5 is waiting.
        do_reset(8'h00);
        cycle(8'h28, 8'h08);
        check_val("early_s4_first", 32'(s4), 32'd3);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h20, 8'($urandom));
            check_val("early_s4", 32'(s4), 32'd5);
            check_val("early_cnt4", 32'(u_dut4.cnt_q), 32'(k));
        end

        // Wrap-around: owner 7 expires with 0 also pending, next grant is 0.
        do_reset(8'h00);
        cycle(8'h80, 8'h80);
        check_val("wrap_s4_first", 32'(s4), 32'd7);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h81, 8'($urandom));
            if (k == 1) check_val("wrap_s2", 32'(s2), 32'd0);
        end
        check_val("wrap_s4", 32'(s4), 32'd0);

        // Reset during a tenure of requester 6, then restart from index 0.
        do_reset(8'h00);
        cycle(8'h40, 8'h40);
        cycle(8'h40, 8'h40);
        check_val("pre_rst_s4", 32'(s4), 32'd6);
        do_reset(8'h50);
        cycle(8'h50, 8'h10);
        check_val("post_rst_s4", 32'(s4), 32'd4);
        check_val("post_rst_s2", 32'(s2), 32'd4);

        // Random traffic with sparse and dense request mixes and occasional resets.
        for (int k = 0; k < 400; k++) begin
            if (k % 97 == 96) begin
                do_reset(8'($urandom));
            end
            if (k % 3 == 0) begin
                cycle(8'($urandom) & 8'($urandom), 8'($urandom));
            end else begin
                cycle(8'($urandom), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 8:1 single-bit selection channel among eight requesters. It owns the 3-bit select, issues a registered one-hot grant, bounds each tenure to a programmable number of cycles, and drives the selected requester's data bit onto a single output. It sits between the eight request sources and the shared downstream consumer, which takes the channel bit plus a valid flag.

## Interface
Parameters:
- HOLD_MAX, 4: maximum cycles one grant tenure lasts. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector; req[n] high means requester n wants the channel.
- i  input  8  data bits; i[n] belongs to requester n.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- s  output  3  registered select, the binary index of the granted requester.
- valid  output  1  registered; high while a grant is active.
- Y  output  1  combinational; i[s] & valid.

## Operation
- States: IDLE, GRANT. Internal registers: ptr[2:0] (search start), owner[2:0], cnt (enough bits for HOLD_MAX-1).
- Pick function: the first index n with req[n]=1, searching ptr, ptr+1, …, ptr+7 modulo 8.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise go to GRANT with owner = pick, gnt = 1<<pick, s = pick, valid = 1, cnt = 0.
- GRANT, end of tenure. The tenure ends when req[owner] == 0 or cnt == HOLD_MAX-1.
  - If the tenure does not end: cnt increments and all outputs hold.
  - If the tenure ends: ptr = owner+1 (mod 8). Re-arbitrate in the same cycle using the new ptr and the current req, with owner masked only when req[owner] == 0.
    - A winner exists: move to that winner directly, with no idle bubble and cnt = 0.
    - No winner: go to IDLE, gnt = 0, valid = 0. s holds its last value.
  - If the owner still requests when HOLD_MAX expires and no other requester is pending, the owner wins a fresh tenure.
- Requests need no acknowledgement handshake. A requester may drop req at any time, and its tenure ends at the next edge.
- Y is never high while valid is low.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, gnt = 8'h00, s = 3'd0, valid = 0, ptr = 0, owner = 0, cnt = 0. Y is therefore 0.
- Latency: a req rising in cycle k while IDLE gives gnt, s and valid at edge k+1. Y follows i combinationally from that point.
- Tenure length: at most HOLD_MAX cycles of valid per grant. With HOLD_MAX = 1, the grant rotates every cycle among the active requesters.
- Handover: back-to-back. valid stays high across the change of owner, and s/gnt change on the same edge.
- Release: when req[owner] falls in cycle k, the grant moves or clears at edge k+1. The owner keeps the channel for that one cycle.
- Simultaneous requests are resolved only by rotating priority from ptr. There is no fixed priority.
- Reset mid-tenure: all outputs clear immediately, and the next grant after reset searches from index 0.

## Structure
- Shared package rr_mux_pkg holds:
  - NREQ = 8 and SELW = 3.
  - The state enum {IDLE, GRANT}.
  - A function idx_to_onehot.
- One natural sub-module, rr_pick. It is purely combinational: inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0], the rotate-then-priority search. The top level holds the FSM, counter, pointer and output registers.

## Test plan
- Single requester: with HOLD_MAX = 4, req = 8'h04 held and i[2] toggling.
  - Required: gnt = 8'h04, s = 2, valid = 1 from the cycle after req rises.
  - Required: a fresh tenure every 4 cycles with s unchanged and Y tracking i[2].
- Rotation: req = 8'hFF held, HOLD_MAX = 2.
  - Required: s steps 0,1,2,…,7,0, each value lasting 2 cycles, with valid continuously high.
- Early release: owner 3 drops req after 1 cycle while req[5] is high.
  - Required: s = 5 on the next edge and cnt restarts, so 5 holds for up to HOLD_MAX cycles.
- Wrap-around fairness: owner 7 releases while req = 8'h81.
  - Required: the next grant is 0 (the search wraps from ptr = 0), not 7.
- Go idle: the only requester drops req.
  - Required: gnt = 0 and valid = 0 on the next edge, s holds its last value, and Y = 0 regardless of i.
- Reset mid-operation: assert rst asynchronously during a tenure of requester 6.
  - Required: gnt = 0, valid = 0, s = 0 immediately.
  - Then release rst with req = 8'h50: the next grant is 4.
